ika87ad_microcode_sequencer: RTL and testbench
==============================================

Name: ika87ad_microcode_sequencer

Overview:
- Microcode address sequencer sitting directly upstream of the microcode ROM.
- Generates the ROM address and read tick, stepping through a decoded instruction's microcode entries, then returning to the instruction-read (IRD) entry.
- Handles decoder handoff, interrupt entry insertion, bus wait stalls, suspension hold (HLT/STOP), and abort.

Parameters:
- IRD_ADDR, 8'd127, ROM address of the IRD wait-for-decode entry.
- INT_ADDR, 8'd96, ROM start address of the interrupt-entry microroutine.
- INT_LEN, 2'd3, step count minus one of the interrupt microroutine.

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  asynchronous reset, active-high.
- i_CEN  in  1  machine-cycle clock enable; a sequencer step can only occur when high.
- i_STALL  in  1  bus wait; blocks the tick and all state updates.
- i_ABORT  in  1  synchronous abort; return to IRD.
- i_DEC_VALID  in  1  decoder has a start address ready.
- i_DEC_START_ADDR  in  8  first microcode address of the decoded instruction.
- i_DEC_LEN  in  2  microcode step count minus one (0..3).
- i_INT_REQ  in  1  pending interrupt, level.
- i_SUSP_HOLD  in  1  keep re-executing the last step (HLT/STOP suspension).
- o_MCROM_READ_TICK  out  1  ROM read strobe.
- o_MCROM_ADDR  out  8  ROM address.
- o_MC_STEP  out  2  index of the current step within the routine.
- o_BUSY  out  1  high while in RUN.
- o_DEC_ACK  out  1  one-cycle pulse when the decoder start address is consumed.
- o_INT_ACK  out  1  one-cycle pulse when the interrupt routine is entered.
- o_INSTR_DONE  out  1  one-cycle pulse when the last step retires.

Behaviour:
- Reset (async): state = S_IRD, o_MCROM_ADDR = IRD_ADDR, step = 0, last = 0, all pulse outputs = 0, o_BUSY = 0.
- Tick: o_MCROM_READ_TICK = i_CEN & ~i_STALL & ~i_RST (combinational).
- All state updates occur only on posedges where the tick is high. The exception is i_ABORT, which is honoured on any posedge with i_CEN = 1, even while stalled.
- The ROM latches data for the current o_MCROM_ADDR on the tick edge. The sequencer presents the next address on the same edge, so ROM data lags the address by one tick.
- Registers: state, addr[7:0], step[1:0], last[1:0].
- S_IRD, on tick:
  - i_INT_REQ = 1 (priority over decode): addr <= INT_ADDR, last <= INT_LEN, step <= 0, o_INT_ACK pulse, go to S_RUN.
  - Else i_DEC_VALID = 1: addr <= i_DEC_START_ADDR, last <= i_DEC_LEN, step <= 0, o_DEC_ACK pulse, go to S_RUN.
  - Else: stay; addr stays at IRD_ADDR.
- S_RUN, on tick:
  - step != last: addr <= addr + 1 (8-bit, wraps 255 -> 0), step <= step + 1.
  - step == last and i_SUSP_HOLD = 1: hold addr and step; no pulse.
  - step == last and i_SUSP_HOLD = 0: addr <= IRD_ADDR, step <= 0, o_INSTR_DONE pulse, go to S_IRD.
  - With last = 0, a single-step routine completes on its first tick.
- Abort: on an i_CEN posedge, state <= S_IRD, addr <= IRD_ADDR, step <= 0. No DONE or ACK pulses. Takes priority over all other events.
- The decoder holds i_DEC_VALID and i_DEC_START_ADDR until o_DEC_ACK. When an interrupt wins, the decode remains pending and is accepted after the interrupt routine returns to IRD.
- i_DEC_VALID and i_INT_REQ are ignored while in S_RUN.
- Pulse outputs are high for exactly one i_CLK cycle following the causing edge.
- o_BUSY = (state == S_RUN). o_MC_STEP = step.

Test Plan:
- Reset, then idle: o_MCROM_ADDR = 127, o_BUSY = 0. Hold i_CEN = 1; the tick is high every cycle and the address stays 127.
- Decode start = 32, len = 3 with i_CEN = 1 continuous: addresses 127, 32, 33, 34, 35, 127. o_DEC_ACK on the first edge, o_INSTR_DONE on the fifth. o_MC_STEP reads 0, 1, 2, 3.
- i_STALL for 3 cycles during step 1 of start = 4, len = 1: address frozen at 5 and tick low for those 3 cycles, then 127. Only one o_INSTR_DONE.
- i_INT_REQ and i_DEC_VALID both high in IRD: address goes 96..99 with o_INT_ACK. After return to 127, the decode (start = 10, len = 0) is accepted: 10, then 127.
- Suspend: start = 30, len = 1, i_SUSP_HOLD = 1. Address sits at 31 for 5 ticks; release gives 127 plus o_INSTR_DONE. Also check start = 255, len = 1, which wraps to 0.
- i_ABORT during step 2 while i_STALL = 1: next edge shows address 127 and S_IRD, with no o_INSTR_DONE. Asserting i_RST mid-routine asynchronously forces 127 and o_BUSY = 0.

Source files
------------

// File: rtl/ika87ad_microcode_sequencer.sv
// Microcode ROM address sequencer: steps through a decoded routine, inserts the
// interrupt-entry routine, and returns to the IRD entry when the routine retires.
//
// state | meaning
// S_IRD | parked on IRD_ADDR, waiting for an interrupt or a decoded start address
// S_RUN | stepping addr/step through the active routine until step == last
module ika87ad_microcode_sequencer #(
   parameter logic [7:0] IRD_ADDR = 8'd127,
   parameter logic [7:0] INT_ADDR = 8'd96,
   parameter logic [1:0] INT_LEN  = 2'd3
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_CEN,
   input  logic       i_STALL,
   input  logic       i_ABORT,
   input  logic       i_DEC_VALID,
   input  logic [7:0] i_DEC_START_ADDR,
   input  logic [1:0] i_DEC_LEN,
   input  logic       i_INT_REQ,
   input  logic       i_SUSP_HOLD,
   output logic       o_MCROM_READ_TICK,
   output logic [7:0] o_MCROM_ADDR,
   output logic [1:0] o_MC_STEP,
   output logic       o_BUSY,
   output logic       o_DEC_ACK,
   output logic       o_INT_ACK,
   output logic       o_INSTR_DONE
);

   typedef enum logic {S_IRD, S_RUN} state_t;

   state_t     state;
   logic [7:0] addr;
   logic [1:0] step;
   logic [1:0] last;
   logic       tick;
   logic       dec_ack;
   logic       int_ack;
   logic       instr_done;

   assign tick = i_CEN & ~i_STALL & ~i_RST;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state      <= S_IRD;
         addr       <= IRD_ADDR;
         step       <= 2'd0;
         last       <= 2'd0;
         dec_ack    <= 1'b0;
         int_ack    <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         dec_ack    <= 1'b0;
         int_ack    <= 1'b0;
         instr_done <= 1'b0;
         // abort only needs the machine-cycle enable, so it cuts through bus stalls
         if (i_CEN && i_ABORT) begin
            state <= S_IRD;
            addr  <= IRD_ADDR;
            step  <= 2'd0;
         end else if (tick) begin
            case (state)
               S_IRD: begin
                  if (i_INT_REQ) begin
                     state   <= S_RUN;
                     addr    <= INT_ADDR;
                     last    <= INT_LEN;
                     step    <= 2'd0;
                     int_ack <= 1'b1;
                  end else if (i_DEC_VALID) begin
                     state   <= S_RUN;
                     addr    <= i_DEC_START_ADDR;
                     last    <= i_DEC_LEN;
                     step    <= 2'd0;
                     dec_ack <= 1'b1;
                  end else begin
                     addr <= IRD_ADDR;
                  end
               end
               S_RUN: begin
                  if (step != last) begin
                     addr <= addr + 8'd1;
                     step <= step + 2'd1;
                  end else if (!i_SUSP_HOLD) begin
                     state      <= S_IRD;
                     addr       <= IRD_ADDR;
                     step       <= 2'd0;
                     instr_done <= 1'b1;
                  end
               end
               default: begin
                  state <= S_IRD;
                  addr  <= IRD_ADDR;
                  step  <= 2'd0;
               end
            endcase
         end
      end
   end

   assign o_MCROM_READ_TICK = tick;
   assign o_MCROM_ADDR      = addr;
   assign o_MC_STEP         = step;
   assign o_BUSY            = (state == S_RUN);
   assign o_DEC_ACK         = dec_ack;
   assign o_INT_ACK         = int_ack;
   assign o_INSTR_DONE      = instr_done;

endmodule

// File: tb/tb_ika87ad_microcode_sequencer.sv
// Directed bench for the microcode sequencer: decode, stall, interrupt priority,
// suspension hold, address wrap, CEN gating, abort and async reset.
module tb_ika87ad_microcode_sequencer;

   logic       i_CLK = 1'b0;
   logic       i_RST;
   logic       i_CEN;
   logic       i_STALL;
   logic       i_ABORT;
   logic       i_DEC_VALID;
   logic [7:0] i_DEC_START_ADDR;
   logic [1:0] i_DEC_LEN;
   logic       i_INT_REQ;
   logic       i_SUSP_HOLD;
   logic       o_MCROM_READ_TICK;
   logic [7:0] o_MCROM_ADDR;
   logic [1:0] o_MC_STEP;
   logic       o_BUSY;
   logic       o_DEC_ACK;
   logic       o_INT_ACK;
   logic       o_INSTR_DONE;

   int checks   = 0;
   int failures = 0;

   ika87ad_microcode_sequencer dut (
      .i_CLK             (i_CLK),
      .i_RST             (i_RST),
      .i_CEN             (i_CEN),
      .i_STALL           (i_STALL),
      .i_ABORT           (i_ABORT),
      .i_DEC_VALID       (i_DEC_VALID),
      .i_DEC_START_ADDR  (i_DEC_START_ADDR),
      .i_DEC_LEN         (i_DEC_LEN),
      .i_INT_REQ         (i_INT_REQ),
      .i_SUSP_HOLD       (i_SUSP_HOLD),
      .o_MCROM_READ_TICK (o_MCROM_READ_TICK),
      .o_MCROM_ADDR      (o_MCROM_ADDR),
      .o_MC_STEP         (o_MC_STEP),
      .o_BUSY            (o_BUSY),
      .o_DEC_ACK         (o_DEC_ACK),
      .o_INT_ACK         (o_INT_ACK),
      .o_INSTR_DONE      (o_INSTR_DONE)
   );

   always #5 i_CLK = ~i_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp_v);
      end
   endtask

   // one active edge, then sample on the following falling edge
   task automatic adv();
      @(negedge i_CLK);
   endtask

   task automatic chk_state(input string tag, input logic [7:0] a, input logic [1:0] s,
                            input logic b);
      chk({tag, ".addr"}, 32'(o_MCROM_ADDR), 32'(a));
      chk({tag, ".step"}, 32'(o_MC_STEP), 32'(s));
      chk({tag, ".busy"}, 32'(o_BUSY), 32'(b));
   endtask

   task automatic chk_pulses(input string tag, input logic dack, input logic iack,
                             input logic done);
      chk({tag, ".dec_ack"}, 32'(o_DEC_ACK), 32'(dack));
      chk({tag, ".int_ack"}, 32'(o_INT_ACK), 32'(iack));
      chk({tag, ".done"}, 32'(o_INSTR_DONE), 32'(done));
   endtask

   task automatic start_dec(input logic [7:0] a, input logic [1:0] l);
      i_DEC_VALID      = 1'b1;
      i_DEC_START_ADDR = a;
      i_DEC_LEN        = l;
      adv();
      i_DEC_VALID      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_RST = 1'b1; i_CEN = 1'b0; i_STALL = 1'b0; i_ABORT = 1'b0;
      i_DEC_VALID = 1'b0; i_DEC_START_ADDR = 8'd0; i_DEC_LEN = 2'd0;
      i_INT_REQ = 1'b0; i_SUSP_HOLD = 1'b0;
      #12;
      chk_state("rst", 8'd127, 2'd0, 1'b0);
      chk_pulses("rst", 1'b0, 1'b0, 1'b0);
      i_CEN = 1'b1;
      #1 chk("rst.tick_in_reset", 32'(o_MCROM_READ_TICK), 32'd0);
      adv(); i_RST = 1'b0;
      #1 chk("idle.tick", 32'(o_MCROM_READ_TICK), 32'd1);
      for (int i = 0; i < 3; i++) begin
         adv();
         chk_state("idle", 8'd127, 2'd0, 1'b0);
         chk("idle.tick_hi", 32'(o_MCROM_READ_TICK), 32'd1);
      end

      // decode 32, len 3
      start_dec(8'd32, 2'd3);
      chk_state("dec.s0", 8'd32, 2'd0, 1'b1);
      chk_pulses("dec.s0", 1'b1, 1'b0, 1'b0);
      adv(); chk_state("dec.s1", 8'd33, 2'd1, 1'b1);
      chk_pulses("dec.s1", 1'b0, 1'b0, 1'b0);
      adv(); chk_state("dec.s2", 8'd34, 2'd2, 1'b1);
      adv(); chk_state("dec.s3", 8'd35, 2'd3, 1'b1);
      chk("dec.s3.done", 32'(o_INSTR_DONE), 32'd0);
      adv(); chk_state("dec.ret", 8'd127, 2'd0, 1'b0);
      chk_pulses("dec.ret", 1'b0, 1'b0, 1'b1);
      adv(); chk("dec.done_clr", 32'(o_INSTR_DONE), 32'd0);

      // stall during step 1 of start 4, len 1
      start_dec(8'd4, 2'd1);
      chk_state("stl.s0", 8'd4, 2'd0, 1'b1);
      adv(); chk_state("stl.s1", 8'd5, 2'd1, 1'b1);
      i_STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stl.tick", 32'(o_MCROM_READ_TICK), 32'd0);
         adv();
         chk_state("stl.hold", 8'd5, 2'd1, 1'b1);
         chk("stl.done", 32'(o_INSTR_DONE), 32'd0);
      end
      i_STALL = 1'b0;
      adv(); chk_state("stl.ret", 8'd127, 2'd0, 1'b0);
      chk("stl.ret.done", 32'(o_INSTR_DONE), 32'd1);
      adv(); chk("stl.done_once", 32'(o_INSTR_DONE), 32'd0);

      // interrupt beats a pending decode
      i_INT_REQ = 1'b1; i_DEC_VALID = 1'b1; i_DEC_START_ADDR = 8'd10; i_DEC_LEN = 2'd0;
      adv(); i_INT_REQ = 1'b0;
      chk_state("int.s0", 8'd96, 2'd0, 1'b1);
      chk_pulses("int.s0", 1'b0, 1'b1, 1'b0);
      adv(); chk_state("int.s1", 8'd97, 2'd1, 1'b1);
      chk("int.ack_clr", 32'(o_INT_ACK), 32'd0);
      adv(); chk_state("int.s2", 8'd98, 2'd2, 1'b1);
      adv(); chk_state("int.s3", 8'd99, 2'd3, 1'b1);
      adv(); chk_state("int.ret", 8'd127, 2'd0, 1'b0);
      chk_pulses("int.ret", 1'b0, 1'b0, 1'b1);
      adv(); i_DEC_VALID = 1'b0;
      chk_state("int.dec", 8'd10, 2'd0, 1'b1);
      chk_pulses("int.dec", 1'b1, 1'b0, 1'b0);
      adv(); chk_state("int.dec_ret", 8'd127, 2'd0, 1'b0);
      chk_pulses("int.dec_ret", 1'b0, 1'b0, 1'b1);

      // suspension hold on the last step
      i_SUSP_HOLD = 1'b1;
      start_dec(8'd30, 2'd1);
      chk_state("sus.s0", 8'd30, 2'd0, 1'b1);
      adv(); chk_state("sus.s1", 8'd31, 2'd1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         adv();
         chk_state("sus.hold", 8'd31, 2'd1, 1'b1);
         chk("sus.done", 32'(o_INSTR_DONE), 32'd0);
      end
      i_SUSP_HOLD = 1'b0;
      adv(); chk_state("sus.ret", 8'd127, 2'd0, 1'b0);
      chk("sus.ret.done", 32'(o_INSTR_DONE), 32'd1);

      // 8-bit address wrap
      start_dec(8'd255, 2'd1);
      chk_state("wrap.s0", 8'd255, 2'd0, 1'b1);
      adv(); chk_state("wrap.s1", 8'd0, 2'd1, 1'b1);
      adv(); chk_state("wrap.ret", 8'd127, 2'd0, 1'b0);
      chk("wrap.done", 32'(o_INSTR_DONE), 32'd1);

      // CEN low freezes everything, including abort
      start_dec(8'd60, 2'd1);
      i_CEN = 1'b0;
      #1 chk("cen.tick", 32'(o_MCROM_READ_TICK), 32'd0);
      adv(); chk_state("cen.hold", 8'd60, 2'd0, 1'b1);
      i_ABORT = 1'b1;
      adv(); chk_state("cen.abort_ign", 8'd60, 2'd0, 1'b1);
      i_ABORT = 1'b0; i_CEN = 1'b1;
      adv(); chk_state("cen.s1", 8'd61, 2'd1, 1'b1);
      adv(); chk_state("cen.ret", 8'd127, 2'd0, 1'b0);

      // abort in step 2 while stalled
      start_dec(8'd50, 2'd3);
      adv(); adv();
      chk_state("abt.s2", 8'd52, 2'd2, 1'b1);
      i_STALL = 1'b1; i_ABORT = 1'b1;
      adv(); chk_state("abt.ird", 8'd127, 2'd0, 1'b0);
      chk_pulses("abt.ird", 1'b0, 1'b0, 1'b0);
      i_STALL = 1'b0; i_ABORT = 1'b0;
      adv(); chk_state("abt.idle", 8'd127, 2'd0, 1'b0);
      chk("abt.no_done", 32'(o_INSTR_DONE), 32'd0);

      // async reset mid-routine
      start_dec(8'd70, 2'd3);
      adv(); chk_state("ar.s1", 8'd71, 2'd1, 1'b1);
      #2 i_RST = 1'b1;
      #1 chk_state("ar.rst", 8'd127, 2'd0, 1'b0);
      adv(); i_RST = 1'b0;
      adv(); chk_state("ar.idle", 8'd127, 2'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
